// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus a one-instruction-in-flight fetch loop toward imem and decode.
// Run-to-issue takes at least 3 cycles. Stalls are on imem_ready, imem_rvalid, ins_ready and pc_update.
module pc_fetch_unit #(
   parameter int unsigned PC_W     = 14,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [DATA_W-1:0] instruction,
   output logic [PC_W-1:0]   pc,
   output logic [31:0]       pc_arti1,
   input  logic              pc_update,
   input  logic [PC_W-1:0]   new_pc,
   output logic              fetch_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_DATA,
      S_ISSUE,
      S_WAIT_NPC
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [DATA_W-1:0]  instr_q, instr_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cnt_hit;

   // The stalled cycle that would bring the count to TIMEOUT is the one that gives up.
   assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_W'(RESET_PC);
         instr_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (run && !err_q) begin
               state_d = S_FETCH;
               cnt_d   = '0;
            end
         end
         S_FETCH: begin
            if (imem_ready) begin
               state_d = S_WAIT_DATA;
               cnt_d   = '0;
            end else if (cnt_hit) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_DATA: begin
            if (imem_rvalid) begin
               state_d = S_ISSUE;
               instr_d = imem_rdata;
            end else if (cnt_hit) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ISSUE: begin
            if (ins_ready) begin
               state_d = S_WAIT_NPC;
            end
         end
         S_WAIT_NPC: begin
            if (pc_update) begin
               pc_d = new_pc;
               if (run) begin
                  state_d = S_FETCH;
                  cnt_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign ins_valid   = (state_q == S_ISSUE);
   assign instruction = instr_q;
   assign pc          = pc_q;
   assign pc_arti1    = {{(32 - PC_W){1'b0}}, pc_q} + 32'd1;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
   localparam int PC_W    = 14;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 255;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              run = 1'b0;
   logic              imem_ready = 1'b0;
   logic              imem_rvalid = 1'b0;
   logic [DATA_W-1:0] imem_rdata = '0;
   logic              ins_ready = 1'b0;
   logic              pc_update = 1'b0;
   logic [PC_W-1:0]   new_pc = '0;
   logic              imem_req, ins_valid, fetch_err;
   logic [PC_W-1:0]   imem_addr, pc;
   logic [DATA_W-1:0] instruction;
   logic [31:0]       pc_arti1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   pc_fetch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .RESET_PC(0), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .instruction(instruction),
      .pc(pc), .pc_arti1(pc_arti1), .pc_update(pc_update), .new_pc(new_pc),
      .fetch_err(fetch_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: where the single in-flight instruction is, plus pc/err.
   bit          m_requesting, m_awaiting_data, m_offered, m_awaiting_pc, m_err;
   int          m_waited, m_pc;
   logic [31:0] m_instr;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_requesting = 0; m_awaiting_data = 0; m_offered = 0; m_awaiting_pc = 0;
         m_err = 0; m_waited = 0; m_pc = 0; m_instr = '0;
      end else if (m_requesting) begin
         m_waited++;
         if (imem_ready) begin
            m_requesting = 0; m_awaiting_data = 1; m_waited = 0;
         end else if (m_waited >= TIMEOUT) begin
            m_requesting = 0; m_err = 1;
         end
      end else if (m_awaiting_data) begin
         m_waited++;
         if (imem_rvalid) begin
            m_awaiting_data = 0; m_offered = 1; m_instr = imem_rdata;
         end else if (m_waited >= TIMEOUT) begin
            m_awaiting_data = 0; m_err = 1;
         end
      end else if (m_offered) begin
         if (ins_ready) begin
            m_offered = 0; m_awaiting_pc = 1;
         end
      end else if (m_awaiting_pc) begin
         if (pc_update) begin
            m_pc = int'(new_pc); m_awaiting_pc = 0;
            m_requesting = run; m_waited = 0;
         end
      end else if (run && !m_err) begin
         m_requesting = 1; m_waited = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_imem_req", {31'b0, imem_req}, {31'b0, m_requesting});
         check("m_ins_valid", {31'b0, ins_valid}, {31'b0, m_offered});
         check("m_fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
         check("m_pc", 32'(pc), 32'(m_pc));
         check("m_imem_addr", 32'(imem_addr), 32'(m_pc));
         check("m_pc_arti1", pc_arti1, 32'(m_pc + 1));
         check("m_instruction", instruction, m_instr);
      end
   end

   task automatic xact(input logic [31:0] data, input logic [PC_W-1:0] npc,
                       input int rdy_dly, input int rv_dly, input int bp, input bit keep_run);
      if (rdy_dly > 0) begin
         imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
      end
      repeat (rdy_dly) @(negedge clk);
      imem_rvalid = 1'b0;
      imem_ready = 1'b1; @(negedge clk); imem_ready = 1'b0;
      repeat (rv_dly) @(negedge clk);
      imem_rvalid = 1'b1; imem_rdata = data; @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = '0;
      repeat (bp) @(negedge clk);
      ins_ready = 1'b1; @(negedge clk); ins_ready = 1'b0;
      if (!keep_run) run = 1'b0;
      pc_update = 1'b1; new_pc = npc; @(negedge clk); pc_update = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, ins_valid}, 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_instr", instruction, 32'd0);
      check("rst_err", {31'b0, fetch_err}, 32'd0);

      rst_n = 1'b1; run = 1'b1; @(negedge clk);
      check("t1_req", {31'b0, imem_req}, 32'd1);
      check("t1_addr", 32'(imem_addr), 32'd0);
      check("t1_arti1", pc_arti1, 32'd1);
      check("t1_valid", {31'b0, ins_valid}, 32'd0);

      imem_ready = 1'b1; @(negedge clk); imem_ready = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h08000005; @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = '0;
      check("t2_latency_valid", {31'b0, ins_valid}, 32'd1);
      check("t2_instr", instruction, 32'h08000005);
      ins_ready = 1'b1; @(negedge clk); ins_ready = 1'b0;
      pc_update = 1'b1; new_pc = 14'd5; @(negedge clk); pc_update = 1'b0;
      check("t2_req", {31'b0, imem_req}, 32'd1);
      check("t2_addr", 32'(imem_addr), 32'd5);
      check("t2_arti1", pc_arti1, 32'd6);

      xact(32'h20000001, 14'd3, 1, 1, 0, 1'b1);
      check("t3_pc3", 32'(pc), 32'd3);
      xact(32'h10000008, 14'd12, 0, 2, 1, 1'b1);
      check("t3_branch_addr", 32'(imem_addr), 32'd12);
      xact(32'h00000008, 14'd10, 2, 0, 0, 1'b1);
      check("t3_jr_addr", 32'(imem_addr), 32'd10);

      imem_ready = 1'b1; @(negedge clk); imem_ready = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF; @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = '0;
      pc_update = 1'b1; new_pc = 14'd99;
      for (int i = 0; i < 5; i++) begin
         check("t4_valid", {31'b0, ins_valid}, 32'd1);
         check("t4_instr", instruction, 32'hDEADBEEF);
         check("t4_req", {31'b0, imem_req}, 32'd0);
         check("t4_pc", 32'(pc), 32'd10);
         @(negedge clk);
      end
      pc_update = 1'b0;
      ins_ready = 1'b1; @(negedge clk); ins_ready = 1'b0;
      pc_update = 1'b1; new_pc = 14'd16383; @(negedge clk); pc_update = 1'b0;
      check("t4_max_addr", 32'(imem_addr), 32'd16383);
      check("t4_max_arti1", pc_arti1, 32'd16384);

      xact(32'h0000000F, 14'd7, 0, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("park_req", {31'b0, imem_req}, 32'd0);
         check("park_pc", 32'(pc), 32'd7);
         @(negedge clk);
      end
      run = 1'b1; @(negedge clk);
      check("resume_req", {31'b0, imem_req}, 32'd1);
      check("resume_addr", 32'(imem_addr), 32'd7);

      repeat (TIMEOUT - 1) @(negedge clk);
      check("t5_pre_req", {31'b0, imem_req}, 32'd1);
      check("t5_pre_err", {31'b0, fetch_err}, 32'd0);
      @(negedge clk);
      check("t5_err", {31'b0, fetch_err}, 32'd1);
      check("t5_req", {31'b0, imem_req}, 32'd0);
      repeat (10) @(negedge clk);
      check("t5_stay_req", {31'b0, imem_req}, 32'd0);
      check("t5_stay_err", {31'b0, fetch_err}, 32'd1);

      rst_n = 1'b0; @(negedge clk);
      check("t6_err_cleared", {31'b0, fetch_err}, 32'd0);
      rst_n = 1'b1; @(negedge clk);
      imem_ready = 1'b1; @(negedge clk); imem_ready = 1'b0;
      rst_n = 1'b0; run = 1'b0; @(negedge clk);
      rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D; @(negedge clk);
      imem_rvalid = 1'b0; imem_rdata = '0; @(negedge clk);
      check("t6_pc", 32'(pc), 32'd0);
      check("t6_valid", {31'b0, ins_valid}, 32'd0);
      check("t6_instr", instruction, 32'd0);
      check("t6_req", {31'b0, imem_req}, 32'd0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
